// File: rtl/lsu_mem_if_if.sv
// Data-memory port of the load/store unit.
// The LSU drives request/payload; memory returns ready, rvalid and rdata.
interface lsu_mem_if_if;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_wmask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr,
    output o_mem_wmask, o_mem_wdata,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr,
    input  o_mem_wmask, o_mem_wdata,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: drives the data-memory port, aligns and extends loads.
// Optional bus-error timeout is built when LSU_TIMEOUT_EN is defined.
module lsu_mem_if #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_is_word,
  input  logic        i_is_h_or_b,
  input  logic        i_is_unsigned_ld,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [4:0]  o_rd_addr,
  output logic        o_misalign,
  output logic        o_bus_err,
  lsu_mem_if_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        access;
  logic        mis;
  logic        tmo;
  logic [1:0]  size_d;
  logic [1:0]  size_q;
  logic [1:0]  off;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] ext;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [3:0]  wmask;
  logic [31:0] wdata_rep;
  logic        uns_q;
  logic        we_q;
  logic        mis_q;
  logic        err_q;
  logic [4:0]  rd_q;

  assign access = i_valid & (i_mem_read | i_mem_write);
  assign size_d = i_is_word ? 2'b10 : {1'b0, i_is_h_or_b};
  assign off    = addr_q[1:0];

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      i_is_word:                 mis = |i_addr[1:0];
      ~i_is_word & i_is_h_or_b:  mis = i_addr[0];
      default:                   mis = 1'b0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == REQ || state == RESP) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tmo = (state == REQ || state == RESP) &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (access) state_nx = mis ? DONE : REQ;
      end
      REQ: begin
        if (mem.i_mem_ready) state_nx = we_q ? DONE : RESP;
        else if (tmo)        state_nx = DONE;
      end
      RESP: begin
        if (mem.i_mem_rvalid) state_nx = DONE;
        else if (tmo)         state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;
  end

  assign lane8  = mem.i_mem_rdata[{off, 3'b000} +: 8];
  assign lane16 = mem.i_mem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    ext = mem.i_mem_rdata;
    unique case (size_q)
      2'b00:   ext = {{24{lane8[7] & ~uns_q}}, lane8};
      2'b01:   ext = {{16{lane16[15] & ~uns_q}}, lane16};
      default: ext = mem.i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state == IDLE && access) begin
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
      size_q  <= size_d;
      uns_q   <= i_is_unsigned_ld;
      we_q    <= i_mem_write;
      rd_q    <= i_rd_addr;
      mis_q   <= mis;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state == RESP && mem.i_mem_rvalid) begin
      rdata_q <= ext;
    end else if (tmo && !(state == REQ && mem.i_mem_ready)) begin
      err_q   <= 1'b1;
    end
  end

  always_comb begin
    wmask     = 4'b0000;
    wdata_rep = wdata_q;
    unique case (size_q)
      2'b00: begin
        wmask     = 4'b0001 << off;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask     = 4'b0011 << off;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask     = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
    if (!we_q) wmask = 4'b0000;
  end

  assign o_busy = (state == REQ) || (state == RESP) ||
                  (state == IDLE && access);
  assign o_done     = (state == DONE);
  assign o_rdata    = rdata_q;
  assign o_rd_addr  = rd_q;
  assign o_misalign = mis_q;
  assign o_bus_err  = err_q;

  assign mem.o_mem_req   = (state == REQ);
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.o_mem_wmask = wmask;
  assign mem.o_mem_wdata = wdata_rep;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if against a byte-level model.
// Timeout scenario follows LSU_TIMEOUT_EN (TIMEOUT_CYCLES=8 when built).
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_is_word;
  logic        i_is_h_or_b;
  logic        i_is_unsigned_ld;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd_addr;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic [4:0]  o_rd_addr;
  logic        o_misalign;
  logic        o_bus_err;

  int errors = 0;
  int checks = 0;

  lsu_mem_if_if bus ();

  lsu_mem_if #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_valid          (i_valid),
    .i_mem_read       (i_mem_read),
    .i_mem_write      (i_mem_write),
    .i_is_word        (i_is_word),
    .i_is_h_or_b      (i_is_h_or_b),
    .i_is_unsigned_ld (i_is_unsigned_ld),
    .i_addr           (i_addr),
    .i_wdata          (i_wdata),
    .i_rd_addr        (i_rd_addr),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_rdata          (o_rdata),
    .o_rd_addr        (o_rd_addr),
    .o_misalign       (o_misalign),
    .o_bus_err        (o_bus_err),
    .mem              (bus.master)
  );

  always #5 clk = ~clk;

  int          t_cycles;
  bit          t_done;
  bit          t_done_next;
  bit          t_req_seen;
  bit          t_stable;
  bit          t_busy_ok;
  bit          t_busy0;
  logic [31:0] t_rdata;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_mask;
  logic        t_we;
  logic        t_mis;
  logic        t_err;
  logic [4:0]  t_rd;

  function automatic logic [31:0] m_load(int n, bit uns,
                                         logic [31:0] a,
                                         logic [31:0] d);
    longint v;
    longint span;
    int o;
    o = int'(a[1:0]);
    span = longint'(1) << (8 * n);
    v = (longint'(d) >> (8 * o)) % span;
    if (!uns && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_mask(int n, logic [31:0] a);
    logic [3:0] m;
    int o;
    m = '0;
    o = int'(a[1:0]);
    for (int b = 0; b < 4; b++)
      if (b >= o && b < o + n) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(int n, logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = w[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic bit m_mis(int n, logic [31:0] a);
    return (int'(a[1:0]) % n) != 0;
  endfunction

  task automatic clear_in();
    i_valid          = 1'b0;
    i_mem_read       = 1'b0;
    i_mem_write      = 1'b0;
    i_is_word        = 1'b0;
    i_is_h_or_b      = 1'b0;
    i_is_unsigned_ld = 1'b0;
    i_addr           = '0;
    i_wdata          = '0;
    i_rd_addr        = '0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
  endtask

  task automatic run_txn(input bit rd, input bit wr, input int n,
                         input bit uns, input logic [31:0] a,
                         input logic [31:0] w, input logic [4:0] rda,
                         input int rdly, input int vdly,
                         input logic [31:0] mdata, input bit noise);
    int  req_n;
    int  resp_n;
    bit  in_resp;
    req_n = 0;
    resp_n = 0;
    in_resp = 0;
    t_done = 0;
    t_cycles = 0;
    t_req_seen = 0;
    t_stable = 1;
    t_busy_ok = 1;
    @(negedge clk);
    i_valid          = 1'b1;
    i_mem_read       = rd;
    i_mem_write      = wr;
    i_is_word        = (n == 4);
    i_is_h_or_b      = (n == 2);
    i_is_unsigned_ld = uns;
    i_addr           = a;
    i_wdata          = w;
    i_rd_addr        = rda;
    #1 t_busy0 = o_busy;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_mem_read = 1'b0;
      i_mem_write = 1'b0;
      bus.i_mem_ready  = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = $urandom();
      if (o_done) begin
        t_done   = 1;
        t_cycles = c;
        t_rdata  = o_rdata;
        t_rd     = o_rd_addr;
        t_mis    = o_misalign;
        t_err    = o_bus_err;
        if (o_busy || bus.o_mem_req) t_busy_ok = 0;
        break;
      end
      if (!o_busy) t_busy_ok = 0;
      if (bus.o_mem_req) begin
        if (!t_req_seen) begin
          t_addr  = bus.o_mem_addr;
          t_mask  = bus.o_mem_wmask;
          t_wdata = bus.o_mem_wdata;
          t_we    = bus.o_mem_we;
        end else if (bus.o_mem_addr !== t_addr ||
                     bus.o_mem_wmask !== t_mask ||
                     bus.o_mem_wdata !== t_wdata ||
                     bus.o_mem_we !== t_we) begin
          t_stable = 0;
        end
        t_req_seen = 1;
        req_n++;
        if (noise) bus.i_mem_rvalid = 1'($urandom_range(0, 1));
        if (req_n == rdly + 1) begin
          bus.i_mem_ready = 1'b1;
          in_resp = !wr;
        end
      end else if (in_resp) begin
        resp_n++;
        if (resp_n == vdly + 1) begin
          bus.i_mem_rvalid = 1'b1;
          bus.i_mem_rdata  = mdata;
        end
      end
    end
    checks++;
    if (!t_done) begin
      errors++;
      $display("FAIL txn_no_done addr=%h got=0 want=1", a);
    end
    @(negedge clk);
    t_done_next = o_done;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got=%b want=0", bus.o_mem_req);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got=%b want=0", o_busy);
    end
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b want=0", o_done);
    end
    checks++;
    if (o_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata got=%h want=0", o_rdata);
    end
    checks++;
    if ({o_misalign, o_bus_err} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flags got=%b%b want=00", o_misalign, o_bus_err);
    end
    checks++;
    if (bus.o_mem_wmask !== 4'h0) begin
      errors++;
      $display("FAIL rst_wmask got=%h want=0", bus.o_mem_wmask);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sb();
    run_txn(0, 1, 1, 0, 32'h1003, 32'hA5, 5'd0, 0, 0, 0, 0);
    checks++;
    if (t_mask !== 4'b1000) begin
      errors++;
      $display("FAIL sb_mask got=%b want=1000", t_mask);
    end
    checks++;
    if (t_wdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL sb_wdata got=%h want=a5a5a5a5", t_wdata);
    end
    checks++;
    if (t_addr !== 32'h1000 || t_we !== 1'b1) begin
      errors++;
      $display("FAIL sb_addr got=%h/%b want=1000/1", t_addr, t_we);
    end
    checks++;
    if (t_cycles != 2) begin
      errors++;
      $display("FAIL sb_lat got=%0d want=2", t_cycles);
    end
    checks++;
    if (t_busy0 !== 1'b1 || t_done_next !== 1'b0) begin
      errors++;
      $display("FAIL sb_busy_pulse got=%b%b want=10", t_busy0, t_done_next);
    end
    checks++;
    if (t_rdata !== 32'h0 || t_mis !== 1'b0) begin
      errors++;
      $display("FAIL sb_rdata got=%h want=0", t_rdata);
    end
  endtask

  task automatic test_loads();
    run_txn(1, 0, 2, 0, 32'h2002, 32'h0, 5'd5, 0, 0, 32'h80010000, 0);
    checks++;
    if (t_rdata !== 32'hFFFF8001 || t_rd !== 5'd5) begin
      errors++;
      $display("FAIL lh got=%h rd=%0d want=ffff8001 rd=5", t_rdata, t_rd);
    end
    checks++;
    if (t_cycles != 3 || t_mask !== 4'h0) begin
      errors++;
      $display("FAIL lh_lat got=%0d/%h want=3/0", t_cycles, t_mask);
    end
    run_txn(1, 0, 2, 1, 32'h2002, 32'h0, 5'd6, 0, 0, 32'h80010000, 0);
    checks++;
    if (t_rdata !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu got=%h want=00008001", t_rdata);
    end
    run_txn(1, 0, 4, 0, 32'h2000, 32'h0, 5'd7, 0, 0, 32'h80010000, 0);
    checks++;
    if (t_rdata !== 32'h80010000) begin
      errors++;
      $display("FAIL lw got=%h want=80010000", t_rdata);
    end
  endtask

  task automatic test_misalign();
    run_txn(1, 0, 4, 0, 32'h3001, 32'h0, 5'd3, 0, 0, 32'hFFFFFFFF, 0);
    checks++;
    if (t_mis !== 1'b1 || t_cycles != 1) begin
      errors++;
      $display("FAIL lw_mis got=%b/%0d want=1/1", t_mis, t_cycles);
    end
    checks++;
    if (t_req_seen || t_rdata !== 32'h0) begin
      errors++;
      $display("FAIL lw_mis_req got=%b/%h want=0/0", t_req_seen, t_rdata);
    end
    run_txn(0, 1, 2, 0, 32'h0001, 32'h1234, 5'd0, 0, 0, 32'h0, 0);
    checks++;
    if (t_mis !== 1'b1 || t_req_seen) begin
      errors++;
      $display("FAIL sh_mis got=%b/%b want=1/0", t_mis, t_req_seen);
    end
  endtask

  task automatic test_stall();
    run_txn(0, 1, 4, 0, 32'h4000, 32'h12345678, 5'd0, 5, 0, 32'h0, 0);
    checks++;
    if (!t_stable || !t_busy_ok) begin
      errors++;
      $display("FAIL stall_hold got=%b%b want=11", t_stable, t_busy_ok);
    end
    checks++;
    if (t_cycles != 7) begin
      errors++;
      $display("FAIL stall_lat got=%0d want=7", t_cycles);
    end
    checks++;
    if (t_mask !== 4'hF || t_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL stall_payload got=%h/%h want=f/12345678",
               t_mask, t_wdata);
    end
  endtask

  task automatic test_ignored_and_both();
    bit bad;
    bad = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_addr  = 32'h5000;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL nop_busy got=%b want=0", o_busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.o_mem_req || o_done || o_busy) bad = 1;
    end
    i_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL nop_ignored got=active want=idle");
    end
    run_txn(1, 1, 2, 0, 32'h6002, 32'hBEEF, 5'd9, 0, 0, 32'hFFFFFFFF, 0);
    checks++;
    if (t_we !== 1'b1 || t_mask !== 4'b1100 || t_cycles != 2) begin
      errors++;
      $display("FAIL both_store got=%b/%b/%0d want=1/1100/2",
               t_we, t_mask, t_cycles);
    end
    checks++;
    if (t_rdata !== 32'h0 || t_wdata !== 32'hBEEFBEEF) begin
      errors++;
      $display("FAIL both_data got=%h/%h want=0/beefbeef",
               t_rdata, t_wdata);
    end
  endtask

  task automatic test_reset_in_resp();
    bit bad;
    bad = 0;
    @(negedge clk);
    i_valid    = 1'b1;
    i_mem_read = 1'b1;
    i_is_word  = 1'b1;
    i_addr     = 32'h4000;
    @(negedge clk);
    clear_in();
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_mem_req, o_busy, o_done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_resp got=%b%b%b want=000",
               bus.o_mem_req, o_busy, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h11223344;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (o_done || o_busy || bus.o_mem_req) bad = 1;
    end
    bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_late_rvalid got=active want=idle");
    end
    run_txn(1, 0, 1, 0, 32'h7001, 32'h0, 5'd12, 0, 0, 32'h00008000, 0);
    checks++;
    if (t_rdata !== 32'hFFFFFF80 || t_cycles != 3 || t_rd !== 5'd12) begin
      errors++;
      $display("FAIL rst_lb got=%h/%0d want=ffffff80/3", t_rdata, t_cycles);
    end
  endtask

  task automatic test_random();
    int          n;
    int          op;
    bit          uns;
    bit          st;
    bit          mis;
    int          rdly;
    int          vdly;
    int          ecyc;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] d;
    logic [31:0] erd;
    logic [4:0]  rda;
    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 2);
      n    = 1 << $urandom_range(0, 2);
      uns  = 1'($urandom_range(0, 1));
      a    = $urandom();
      w    = $urandom();
      d    = $urandom();
      rda  = 5'($urandom_range(0, 31));
      rdly = $urandom_range(0, 3);
      vdly = $urandom_range(0, 3);
      st   = (op != 0);
      mis  = m_mis(n, a);
      run_txn(op != 1, op != 0, n, uns, a, w, rda, rdly, vdly, d, 1);
      ecyc = mis ? 1 : (st ? 2 + rdly : 3 + rdly + vdly);
      erd  = (mis || st) ? 32'h0 : m_load(n, uns, a, d);
      checks++;
      if (t_cycles != ecyc || t_mis !== mis) begin
        errors++;
        $display("FAIL rnd%0d_lat got=%0d/%b want=%0d/%b",
                 i, t_cycles, t_mis, ecyc, mis);
      end
      checks++;
      if (t_rdata !== erd || t_rd !== rda) begin
        errors++;
        $display("FAIL rnd%0d_rdata got=%h want=%h", i, t_rdata, erd);
      end
      checks++;
      if (t_req_seen == mis || !t_stable || !t_busy_ok || t_done_next) begin
        errors++;
        $display("FAIL rnd%0d_hs got=%b%b%b%b want=%b110",
                 i, t_req_seen, t_stable, t_busy_ok, t_done_next, !mis);
      end
      if (!mis) begin
        checks++;
        if (t_addr !== {a[31:2], 2'b00} || t_we !== st ||
            t_mask !== (st ? m_mask(n, a) : 4'h0)) begin
          errors++;
          $display("FAIL rnd%0d_req got=%h/%b/%b", i, t_addr, t_we, t_mask);
        end
      end
      if (!mis && st) begin
        checks++;
        if (t_wdata !== m_wdata(n, w)) begin
          errors++;
          $display("FAIL rnd%0d_wdata got=%h want=%h",
                   i, t_wdata, m_wdata(n, w));
        end
      end
    end
  endtask

  task automatic test_stuck();
    bit bad;
    int dc;
    bad = 0;
    dc = 0;
    @(negedge clk);
    i_valid     = 1'b1;
    i_mem_write = 1'b1;
    i_is_word   = 1'b1;
    i_addr      = 32'h8000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      clear_in();
      if (o_done && dc == 0) begin
        dc = c;
`ifdef LSU_TIMEOUT_EN
        checks++;
        if (o_bus_err !== 1'b1 || bus.o_mem_req || o_rdata !== 32'h0) begin
          errors++;
          $display("FAIL tmo_err got=%b/%b want=1/0",
                   o_bus_err, bus.o_mem_req);
        end
`endif
      end
      if (dc == 0 && !o_busy) bad = 1;
    end
`ifdef LSU_TIMEOUT_EN
    checks++;
    if (dc != 9) begin
      errors++;
      $display("FAIL tmo_lat got=%0d want=9", dc);
    end
    bus.i_mem_rvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_late got=%b want=0", o_done);
    end
`else
    checks++;
    if (bad || dc != 0) begin
      errors++;
      $display("FAIL stuck_busy got=%0d want=0", dc);
    end
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_bus_err !== 1'b0) begin
      errors++;
      $display("FAIL stuck_drain got=%b/%b want=1/0", o_done, o_bus_err);
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sb();
    test_loads();
    test_misalign();
    test_stall();
    test_ignored_and_both();
    test_reset_in_resp();
    test_random();
    test_stuck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
